// File: rtl/dtw_traceback_ctrl_pkg.sv
// Shared constants for the DTW traceback controller: FSM encodings,
// direction codes and default geometry.
package dtw_traceback_ctrl_pkg;

  localparam int COORD_W_DEF    = 5;
  localparam int DIR_W_DEF      = 2;
  localparam int BANDS_DEF      = 6;
  localparam int ADDR_W_DEF     = 6;
  localparam int MAX_STATUS_DEF = 63;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_FETCH = 3'd1;
  localparam state_t ST_WAIT  = 3'd2;
  localparam state_t ST_EMIT  = 3'd3;
  localparam state_t ST_DONE  = 3'd4;

  localparam logic [1:0] DIR_LEFT = 2'd0;
  localparam logic [1:0] DIR_DIAG = 2'd1;
  localparam logic [1:0] DIR_UP   = 2'd2;

endpackage

// File: rtl/dtw_traceback_ctrl.sv
// DTW traceback sequencer: walks from the start point to (0,0), fetching a
// direction word per step and streaming visited points over valid/ready.
module dtw_traceback_ctrl
  import dtw_traceback_ctrl_pkg::*;
#(
  parameter int COORD_W    = COORD_W_DEF,
  parameter int DIR_W      = DIR_W_DEF,
  parameter int BANDS      = BANDS_DEF,
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int MAX_STATUS = MAX_STATUS_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     abort,
  input  logic [COORD_W-1:0]       start_x,
  input  logic [COORD_W-1:0]       start_y,
  output logic                     busy,
  output logic                     done,
  output logic                     err,
  output logic                     dir_rd_en,
  output logic [ADDR_W-1:0]        dir_rd_addr,
  input  logic [BANDS*DIR_W-1:0]   dir_rd_data,
  output logic [COORD_W-1:0]       pc_cur_x,
  output logic [COORD_W-1:0]       pc_cur_y,
  output logic [BANDS*DIR_W-1:0]   pc_chosen,
  input  logic [COORD_W-1:0]       pc_next_x,
  input  logic [COORD_W-1:0]       pc_next_y,
  input  logic                     pc_skip,
  output logic                     path_valid,
  input  logic                     path_ready,
  output logic [COORD_W-1:0]       path_x,
  output logic [COORD_W-1:0]       path_y,
  output logic                     path_last
);

  state_t                   state_q, state_d;
  logic [COORD_W-1:0]       cur_x_q, cur_x_d, cur_y_q, cur_y_d;
  logic [ADDR_W-1:0]        status_q, status_d;
  logic [BANDS*DIR_W-1:0]   chosen_q, chosen_d;
  logic                     err_q, err_d;
  logic                     busy_q, busy_d, done_q, done_d;
  logic                     rd_en_q, rd_en_d, valid_q, valid_d;

  logic [ADDR_W:0]          status_sum_s;
  logic                     at_origin_s, stall_s, ovf_s, term_s;

  // One bit wider than the counter so an overflow is seen rather than wrapped
  assign status_sum_s = {1'b0, status_q} + {{ADDR_W{1'b0}}, 1'b1} + {{ADDR_W{1'b0}}, pc_skip};
  assign at_origin_s  = (cur_x_q == {COORD_W{1'b0}}) && (cur_y_q == {COORD_W{1'b0}});
  assign stall_s      = (pc_next_x == cur_x_q) && (pc_next_y == cur_y_q);
  assign ovf_s        = (status_sum_s > (ADDR_W+1)'(MAX_STATUS));
  assign term_s       = at_origin_s || stall_s || ovf_s;

  always_comb begin
    state_d  = state_q;
    cur_x_d  = cur_x_q;
    cur_y_d  = cur_y_q;
    status_d = status_q;
    chosen_d = chosen_q;
    err_d    = err_q;
    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            cur_x_d  = start_x;
            cur_y_d  = start_y;
            status_d = {ADDR_W{1'b0}};
            err_d    = 1'b0;
            state_d  = ST_FETCH;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_FETCH: state_d = ST_WAIT;
        ST_WAIT: begin
          chosen_d = dir_rd_data;
          state_d  = ST_EMIT;
        end
        ST_EMIT: begin
          if (!path_ready) begin
            state_d = ST_EMIT;
          end else if (at_origin_s) begin
            state_d = ST_DONE;
          end else if (stall_s || ovf_s) begin
            err_d   = 1'b1;
            state_d = ST_DONE;
          end else begin
            cur_x_d  = pc_next_x;
            cur_y_d  = pc_next_y;
            status_d = status_sum_s[ADDR_W-1:0];
            state_d  = ST_FETCH;
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
    busy_d  = (state_d != ST_IDLE);
    done_d  = (state_d == ST_DONE);
    rd_en_d = (state_d == ST_FETCH);
    valid_d = (state_d == ST_EMIT);
  end

  // State, datapath and decoded output flops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cur_x_q  <= {COORD_W{1'b0}};
      cur_y_q  <= {COORD_W{1'b0}};
      status_q <= {ADDR_W{1'b0}};
      chosen_q <= {(BANDS*DIR_W){1'b0}};
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      rd_en_q  <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cur_x_q  <= cur_x_d;
      cur_y_q  <= cur_y_d;
      status_q <= status_d;
      chosen_q <= chosen_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      rd_en_q  <= rd_en_d;
      valid_q  <= valid_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign err         = err_q;
  assign dir_rd_en   = rd_en_q;
  assign dir_rd_addr = status_q;
  assign pc_cur_x    = cur_x_q;
  assign pc_cur_y    = cur_y_q;
  assign pc_chosen   = chosen_q;
  assign path_valid  = valid_q;
  assign path_x      = cur_x_q;
  assign path_y      = cur_y_q;
  // Depends on the external next-point logic, so it cannot be a flop
  assign path_last   = valid_q && term_s;

endmodule
